// File: rtl/spi_xchg_pkg.sv
// Shared definitions for the Lab407 serial exchange controller: FSM states,
// default word width and the constant MASTER/SLAVE data words.
package spi_xchg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } xchg_state_e;

   localparam int DEF_DATA_W = 12;

   localparam logic [DEF_DATA_W-1:0] MASTER_WORD = 12'h702;
   localparam logic [DEF_DATA_W-1:0] SLAVE_WORD  = 12'hE6C;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles,
// restarted from zero whenever clr is high.
module spi_tick_gen
   import spi_xchg_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 8'd0;
      end else if (clr) begin
         r_cnt <= 8'd0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
      end
   end

   assign tick = en && !clr && (r_cnt == LAST);

endmodule

// File: rtl/spi_xchg_ctrl.sv
// SPI mode-0 master exchange controller: shifts tx_dat out MSB-first while
// shifting the reply in. Define SPI_XCHG_LOOPBACK_EN to add the lpbk input.
module spi_xchg_ctrl
   import spi_xchg_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] tx_dat,
   output logic [DATA_W-1:0] rx_dat,
   output logic              busy,
   output logic              done,
   output logic              cs_n,
   output logic              sclk,
   output logic              mosi,
`ifdef SPI_XCHG_LOOPBACK_EN
   input  logic              lpbk,
`endif
   input  logic              miso
);

   localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

   xchg_state_e       r_state;
   logic [DATA_W-1:0] r_tx_sh;
   logic [DATA_W-1:0] r_rx_sh;
   logic [DATA_W-1:0] r_rx_dat;
   logic [5:0]        r_bit_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_cs_n;
   logic              r_sclk;
   logic              r_mosi;

   logic w_tick;
   logic w_active;
   logic w_abort;
   logic w_last_bit;
   logic w_sample;

   assign w_active   = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
   assign w_abort    = abort && w_active;
   assign w_last_bit = (r_bit_cnt == LAST_BIT);

`ifdef SPI_XCHG_LOOPBACK_EN
   assign w_sample = lpbk ? r_mosi : miso;
`else
   assign w_sample = miso;
`endif

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (r_state == IDLE),
      .en    (w_active),
      .tick  (w_tick)
   );

   // sclk rises on a tick while low and falls on a tick while high; the
   // DATA_W-th falling edge ends the shift phase without another tx shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rx_dat  <= '0;
         r_bit_cnt <= 6'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
      end else if (w_abort) begin
         r_state   <= IDLE;
         r_bit_cnt <= 6'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cs_n <= 1'b1;
               r_sclk <= 1'b0;
               r_mosi <= 1'b0;
               if (start && !abort) begin
                  r_state   <= SETUP;
                  r_cs_n    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= 6'd0;
                  r_mosi    <= tx_dat[DATA_W-1];
               end
            end
            SETUP: begin
               if (w_tick) r_state <= SHIFT;
            end
            SHIFT: begin
               if (w_tick) begin
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                  end else begin
                     r_sclk <= 1'b0;
                     if (w_last_bit) begin
                        r_state <= HOLD;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        r_mosi    <= r_tx_sh[DATA_W-2];
                     end
                  end
               end
            end
            HOLD: begin
               if (w_tick) begin
                  r_state  <= DONE;
                  r_cs_n   <= 1'b1;
                  r_done   <= 1'b1;
                  r_rx_dat <= r_rx_sh;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_mosi  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Shift registers carry data only and are fully reloaded each transfer.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && start) begin
         r_tx_sh <= tx_dat;
      end else if (r_state == SHIFT && w_tick && r_sclk && !w_last_bit) begin
         r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
      end
      if (r_state == SHIFT && w_tick && !r_sclk) begin
         r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_sample};
      end
   end

   assign rx_dat = r_rx_dat;
   assign busy   = r_busy;
   assign done   = r_done;
   assign cs_n   = r_cs_n;
   assign sclk   = r_sclk;
   assign mosi   = r_mosi;

endmodule

// File: tb/tb_spi_xchg_ctrl.sv
// Scoreboard bench for spi_xchg_ctrl (DATA_W=12, CLK_DIV=2) with a mode-0
// slave model; the loopback test is included when SPI_XCHG_LOOPBACK_EN is set.
module tb_spi_xchg_ctrl;
   import spi_xchg_pkg::*;

   localparam int N   = 12;
   localparam int D   = 2;
   localparam int LAT = D * (2 * N + 2) + 1;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, miso;
   logic [N-1:0]  tx_dat, rx_dat;
   logic          busy, done, cs_n, sclk, mosi;
   logic          lpbk;

   typedef struct {
      logic [N-1:0] tx;
      logic [N-1:0] rx;
      int           acc;
   } exp_t;

   exp_t         sb_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   int           rises = 0;
   int           cs_low = 0;
   int           slv_idx = 0;
   logic [N-1:0] cap = '0;
   logic [N-1:0] slv_word = '0;
   logic [N-1:0] model_rx = '0;
   logic         prev_cs_n = 1'b1;
   logic         prev_sclk = 1'b0;

   spi_xchg_ctrl #(
      .DATA_W  (N),
      .CLK_DIV (D)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .abort  (abort),
      .tx_dat (tx_dat),
      .rx_dat (rx_dat),
      .busy   (busy),
      .done   (done),
      .cs_n   (cs_n),
      .sclk   (sclk),
      .mosi   (mosi),
`ifdef SPI_XCHG_LOOPBACK_EN
      .lpbk   (lpbk),
`endif
      .miso   (miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor + slave model, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_cs_n && !cs_n) begin
            cap = '0;
            rises = 0;
            slv_idx = 0;
         end
         if (!prev_sclk && sclk) begin
            cap = {cap[N-2:0], mosi};
            rises++;
         end
         if (prev_sclk && !sclk) slv_idx++;
         if (!cs_n) cs_low++;
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("rx_dat", rx_dat, e.rx);
               chk("mosi_word", cap, e.tx);
               chk("sclk_rises", rises, N);
               chk("latency", cyc - e.acc + 1, LAT);
               chk("cs_low_cycles", cs_low, 2 * N * D + 2 * D);
               chk("busy_in_done", busy, 1);
               model_rx = e.rx;
            end
         end
         if (cs_n) cs_low = 0;
      end
      miso = (slv_idx < N) ? slv_word[N-1-slv_idx] : 1'b0;
      prev_cs_n = cs_n;
      prev_sclk = sclk;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Caller is positioned in an IDLE cycle; the request is accepted on the next edge.
   task automatic start_xfer(input logic [N-1:0] tx, input logic [N-1:0] slv);
      exp_t e;
      chk("idle_before_start", busy, 0);
      tx_dat   = tx;
      slv_word = slv;
      start    = 1'b1;
      e.tx  = tx;
      e.rx  = lpbk ? tx : slv;
      e.acc = cyc + 1;
      sb_q.push_back(e);
      tick();
      start  = 1'b0;
      tx_dat = N'($urandom);
   endtask

   task automatic wait_idle(input bit spam);
      int n = 0;
      while (busy && n < 400) begin
         if (spam) begin
            start  = 1'($urandom);
            tx_dat = N'($urandom);
         end
         tick();
         n++;
      end
      start = 1'b0;
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rx_dat"}, rx_dat, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cs_n"}, cs_n, 1);
      chk({tag, "_sclk"}, sclk, 0);
      chk({tag, "_mosi"}, mosi, 0);
   endtask

   task automatic do_abort(input string tag);
      int dc;
      exp_t e;
      abort = 1'b1;
      e = sb_q.pop_back();
      dc = done_cnt;
      tick();
      abort = 1'b0;
      chk({tag, "_cs_n"}, cs_n, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sclk"}, sclk, 0);
      chk({tag, "_mosi"}, mosi, 0);
      repeat (60) tick();
      chk({tag, "_no_done"}, done_cnt, dc);
      chk({tag, "_rx_kept"}, rx_dat, model_rx);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dc;
      int n;
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      tx_dat = '0;
      lpbk   = 1'b0;
      repeat (2) tick();
      chk_reset_outs("reset");
      rst_n = 1'b1;
      tick();

      // Basic exchange
      start_xfer(MASTER_WORD, SLAVE_WORD);
      wait_idle(0);

      // Start while busy must be ignored
      dc = done_cnt;
      start_xfer(MASTER_WORD, SLAVE_WORD);
      repeat (9) tick();
      start  = 1'b1;
      tx_dat = 12'hFFF;
      tick();
      start = 1'b0;
      wait_idle(0);
      chk("one_done_pulse", done_cnt, dc + 1);

      // Abort at the 5th rising sclk edge
      start_xfer(MASTER_WORD, 12'h123);
      n = 0;
      while (rises < 5 && n < 200) begin
         tick();
         n++;
      end
      chk("reach_5th_rise", rises, 5);
      do_abort("abort5");
      chk("rx_keeps_e6c", rx_dat, SLAVE_WORD);

      // Simultaneous start and abort in IDLE
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_cs_n", cs_n, 1);

      // Back-to-back transfers
      start_xfer(MASTER_WORD, SLAVE_WORD);
      wait_idle(0);
      start_xfer(SLAVE_WORD, MASTER_WORD);
      wait_idle(0);

      // Reset mid-shift, then a normal transfer
      start_xfer(MASTER_WORD, SLAVE_WORD);
      repeat (29) tick();
      chk("mid_xfer_cs_n", cs_n, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("async_rst");
      void'(sb_q.pop_back());
      model_rx = '0;
      tick();
      rst_n = 1'b1;
      tick();
      start_xfer(12'h3C5, 12'h9A6);
      wait_idle(0);

`ifdef SPI_XCHG_LOOPBACK_EN
      lpbk = 1'b1;
      start_xfer(12'hA5A, 12'h000);
      wait_idle(0);
      chk("loopback_rx", rx_dat, 12'hA5A);
      lpbk = 1'b0;
`endif

      // Randomised transfers: plain, start spam, mid-transfer abort
      for (int i = 0; i < 20; i++) begin
         int mode;
         mode = $urandom_range(0, 2);
         start_xfer(N'($urandom), N'($urandom));
         if (mode == 2) begin
            repeat ($urandom_range(1, 40)) tick();
            do_abort("rand_abort");
         end else begin
            wait_idle(mode == 1);
         end
      end

      repeat (3) tick();
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_xchg_ctrl.md
Name: spi_xchg_ctrl

Overview:
- Master-side serial exchange controller for the Lab407 12-bit MASTER/SLAVE data words.
- On a start request, latches a parallel transmit word and shifts it out MSB-first on an SPI mode-0 link (CS_n, SCLK, MOSI).
- Shifts the returning word in on MISO at the same time.
- Presents the received word with a one-cycle done pulse.
- Sits between the constant data sources and the board-level serial pins; sequences every transfer.

Parameters:
- DATA_W, 12: word width in bits; legal range 2..32.
- CLK_DIV, 4: system-clock cycles per SCLK half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  transfer request; sampled only in IDLE.
- abort  in  1  synchronous cancel of the transfer in progress.
- tx_dat  in  DATA_W  word to transmit; latched on the cycle start is accepted.
- rx_dat  out  DATA_W  last complete received word.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse when the transfer completes.
- cs_n  out  1  slave select, active low.
- sclk  out  1  serial clock; idles low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; assumed already synchronous to clk.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rx_dat=0, busy=0, done=0, cs_n=1, sclk=0, mosi=0. Divider and bit counters cleared. Takes effect immediately, including mid-transfer.
- States and transitions:
  - IDLE: start=1 latches tx_dat into the shift register, clears the divider, goes to SETUP.
  - SETUP: lasts CLK_DIV cycles. cs_n=0, sclk=0, mosi=shift[DATA_W-1]. Then goes to SHIFT.
  - SHIFT: lasts 2*DATA_W*CLK_DIV cycles. sclk toggles every CLK_DIV cycles, starting with a rising edge.
    - On each rising edge: sample miso into rx_shift[0], shifting left.
    - On each falling edge except the last: shift the tx register left; mosi takes the new MSB.
    - After the DATA_W-th falling edge: go to HOLD.
  - HOLD: lasts CLK_DIV cycles. cs_n=0, sclk=0, mosi holds its last value. Then goes to DONE.
  - DONE: lasts 1 cycle. cs_n=1, done=1, rx_dat<=rx_shift on entry, busy=1. Then goes to IDLE.
- Latency: done is high exactly CLK_DIV*(2*DATA_W+2)+1 cycles after the start-accept edge. With default parameters this is 105 cycles.
- start while busy (including the DONE cycle) is ignored and not queued.
- Simultaneous start and abort in IDLE: abort wins; no transfer starts.
- abort=1 in SETUP, SHIFT or HOLD: next cycle returns to IDLE with cs_n=1, sclk=0, mosi=0, busy=0. No done pulse; rx_dat unchanged.
- abort in DONE: ignored; the completion stands.
- tx_dat changes after acceptance have no effect on the transfer in progress.
- mosi returns to 0 in IDLE.

Optional Feature:
- Macro: SPI_XCHG_LOOPBACK_EN.
- Defined: adds input lpbk (1 bit). When lpbk=1, the internal sample path uses mosi instead of the miso pin, so rx_dat==tx_dat after a transfer. External pins behave unchanged.
- Undefined: no lpbk port; always samples miso.

Decomposition:
- Shared package spi_xchg_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, DONE);
  - localparam DEF_DATA_W=12;
  - default MASTER word 12'h702 and SLAVE word 12'hE6C, used by benches and top level.
- One sub-module, spi_tick_gen: a CLK_DIV counter producing a one-cycle half-period tick. Inputs: clk, rst_n, clr, en. Output: tick.

Test Plan:
- Reset mid-SHIFT: assert rst_n=0 at cycle 30 of a transfer -> outputs immediately at reset values; a subsequent start works normally.
- Basic exchange, CLK_DIV=2: tx_dat=12'h702, slave model returns 12'hE6C -> mosi bit sequence 0,1,1,1,0,0,0,0,0,0,1,0 on 12 rising edges; done at cycle 53 after start; rx_dat=12'hE6C; cs_n low for exactly 52 cycles.
- Start while busy: second start at cycle 10 with tx_dat=12'hFFF -> ignored; transmitted word stays 12'h702; exactly one done pulse.
- Abort at the 5th rising edge -> cs_n=1 and busy=0 next cycle; no done; rx_dat keeps its previous value 12'hE6C.
- Back-to-back: start asserted in the first IDLE cycle after done -> accepted; second transfer with tx_dat=12'hE6C completes in 53 cycles.
- SPI_XCHG_LOOPBACK_EN defined, lpbk=1, miso tied to 0, tx_dat=12'hA5A -> rx_dat=12'hA5A.
